// File: rtl/modex_stream_decryptor.sv
`default_nettype none
// ============================================================================
// Module      : modex_stream_decryptor
// Description : Self-sequencing modular-exponentiation stream decryptor.
//               Walks pixel memory from base_addr_i and packs ARQ/PIX pixel
//               low-bytes per ciphertext word, with the first-read pixel most
//               significant. Each word C is decrypted as C^E mod N and the
//               result is streamed out over a valid/ready handshake.
//
// Ports       : clk, rst        clock, synchronous active-high reset
//               start_i         job request, sampled only while idle
//               base_addr_i     first pixel address
//               word_count_i    number of ciphertext words in the job
//               exponent_i      private exponent E (latched at start)
//               modulus_i       modulus N (latched at start)
//               mem_re_o        memory read enable
//               mem_addr_o      memory read address
//               mem_rdata_i     read data, valid the cycle after mem_re_o
//               out_valid_o     result available
//               out_ready_i     consumer accepts on out_valid_o && out_ready_i
//               out_data_o      plaintext C^E mod N
//               out_cipher_o    ciphertext, zero-extended to 2*ARQ bits
//               out_index_o     0-based word index
//               busy_o          high in every state except idle
//               done_o          one-cycle end-of-job pulse
//               err_o           job rejected because N < 2 (sticky to start)
//
// Revision    : 1.0 - initial release
// ============================================================================
module modex_stream_decryptor #(
    parameter int ARQ   = 16,
    parameter int PIX   = 8,
    parameter int MEM_W = 16,
    parameter int ADDR  = 18,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR-1:0]    base_addr_i,
    input  logic [CNT_W-1:0]   word_count_i,
    input  logic [ARQ-1:0]     exponent_i,
    input  logic [ARQ-1:0]     modulus_i,
    output logic               mem_re_o,
    output logic [ADDR-1:0]    mem_addr_o,
    input  logic [MEM_W-1:0]   mem_rdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ARQ-1:0]     out_data_o,
    output logic [2*ARQ-1:0]   out_cipher_o,
    output logic [CNT_W-1:0]   out_index_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int c_npix  = ARQ / PIX;
    localparam int c_fc_w  = $clog2(c_npix + 1);
    localparam int c_bit_w = (ARQ > 1) ? $clog2(ARQ) : 1;

    localparam logic [c_fc_w-1:0]  c_fc_last      = c_fc_w'(c_npix);
    localparam logic [c_fc_w-1:0]  c_fc_lastissue = c_fc_w'(c_npix - 1);
    localparam logic [c_fc_w-1:0]  c_fc_one       = c_fc_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_last     = c_bit_w'(ARQ - 1);
    localparam logic [c_bit_w-1:0] c_bit_one      = c_bit_w'(1);
    localparam logic [ARQ-1:0]     c_one          = ARQ'(1);
    localparam logic [ARQ-1:0]     c_two          = ARQ'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_REDUCE = 3'd2,
        S_EXP    = 3'd3,
        S_OUT    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Job parameters captured at start
    logic [ADDR-1:0]    addr_q;      // address of the current / last read
    logic [CNT_W-1:0]   cnt_q;
    logic [ARQ-1:0]     exp_q;
    logic [ARQ-1:0]     mod_q;
    logic               err_q;

    // Sequencing counters
    logic [c_fc_w-1:0]  fcnt_q;      // fetch cycle 0..NPIX
    logic [c_bit_w-1:0] bcnt_q;      // multiplier bit step
    logic [c_bit_w-1:0] ecnt_q;      // exponent bit, LSB first
    logic [CNT_W-1:0]   idx_q;       // index of the word being processed

    // Arithmetic state
    logic [ARQ-1:0]     c_q;         // assembled ciphertext word
    logic [ARQ-1:0]     r_q;         // running result R
    logic [ARQ-1:0]     base_q;      // running base (squared each exponent bit)
    logic [ARQ-1:0]     acc_r_q;     // partial product for R * base
    logic [ARQ-1:0]     acc_b_q;     // partial product for base * base / reduce

    // Held result registers
    logic [ARQ-1:0]     out_data_q;
    logic [ARQ-1:0]     out_cipher_q;
    logic [CNT_W-1:0]   out_index_q;

    logic               w_issue;
    logic               w_bad_mod;
    logic               w_bit_last;
    logic               w_exp_last;
    logic               w_more;
    logic               w_mul_bit;
    logic [ARQ-1:0]     w_mul_a;
    logic [ARQ-1:0]     w_acc_b_nx;
    logic [ARQ-1:0]     w_acc_r_nx;

    // One step of the MSB-first interleaved modular multiply:
    // r' = 2r + (bit ? a : 0), then up to two subtractions of n.
    // With r, a < n the sum is below 3n, so two subtractions always suffice.
    function automatic logic [ARQ-1:0] mm_step(
        input logic [ARQ-1:0] r,
        input logic [ARQ-1:0] a,
        input logic [ARQ-1:0] n,
        input logic           bit_i
    );
        logic [ARQ+1:0] t;
        t = {1'b0, r, 1'b0} + (bit_i ? {2'b00, a} : '0);
        if (t >= {2'b00, n}) begin
            t = t - {2'b00, n};
        end
        if (t >= {2'b00, n}) begin
            t = t - {2'b00, n};
        end
        return ARQ'(t);
    endfunction

    assign w_issue    = (state_q == S_FETCH) && (fcnt_q < c_fc_last);
    assign w_bad_mod  = (modulus_i < c_two);
    assign w_bit_last = (bcnt_q == c_bit_last);
    assign w_exp_last = (ecnt_q == c_bit_last);
    assign w_more     = ((idx_q + CNT_W'(1)) != cnt_q);

    // The reduction C mod N is run as modmul(1, C): stepping through the bits
    // of C with a multiplicand of 1 keeps every intermediate below 2N, so the
    // result is correct even when C >= N (which a plain C * 1 walk is not).
    assign w_mul_bit  = (state_q == S_REDUCE) ? c_q[c_bit_last - bcnt_q]
                                              : base_q[c_bit_last - bcnt_q];
    assign w_mul_a    = (state_q == S_REDUCE) ? c_one : base_q;
    assign w_acc_b_nx = mm_step(acc_b_q, w_mul_a, mod_q, w_mul_bit);
    assign w_acc_r_nx = mm_step(acc_r_q, r_q, mod_q, w_mul_bit);

    generate
        if (MEM_W > PIX) begin : g_unused_rdata
            logic w_unused_rdata;
            assign w_unused_rdata = ^mem_rdata_i[MEM_W-1:PIX];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_re_o    = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    if (w_bad_mod || (word_count_i == '0)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                mem_re_o = w_issue;
                if (fcnt_q == c_fc_last) begin
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (w_bit_last) begin
                    state_d = S_EXP;
                end
            end
            S_EXP: begin
                if (w_bit_last && w_exp_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = w_more ? S_FETCH : S_FINISH;
                end
            end
            S_FINISH: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            exp_q        <= '0;
            mod_q        <= '0;
            err_q        <= 1'b0;
            fcnt_q       <= '0;
            bcnt_q       <= '0;
            ecnt_q       <= '0;
            idx_q        <= '0;
            c_q          <= '0;
            r_q          <= '0;
            base_q       <= '0;
            acc_r_q      <= '0;
            acc_b_q      <= '0;
            out_data_q   <= '0;
            out_cipher_q <= '0;
            out_index_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        err_q  <= w_bad_mod;
                        cnt_q  <= word_count_i;
                        exp_q  <= exponent_i;
                        mod_q  <= modulus_i;
                        idx_q  <= '0;
                        fcnt_q <= '0;
                        // Only move the address when reads will follow, so
                        // mem_addr_o stays put on rejected or empty jobs.
                        if (state_d == S_FETCH) begin
                            addr_q <= base_addr_i;
                        end
                    end
                end
                S_FETCH: begin
                    fcnt_q <= fcnt_q + c_fc_one;
                    // Data for the read issued last cycle arrives now.
                    if (fcnt_q != '0) begin
                        c_q <= (c_q << PIX) | ARQ'(mem_rdata_i[PIX-1:0]);
                    end
                    if (w_issue && (fcnt_q != c_fc_lastissue)) begin
                        addr_q <= addr_q + ADDR'(1);
                    end
                    if (fcnt_q == c_fc_last) begin
                        fcnt_q  <= '0;
                        bcnt_q  <= '0;
                        acc_b_q <= '0;
                    end
                end
                S_REDUCE: begin
                    bcnt_q <= bcnt_q + c_bit_one;
                    if (w_bit_last) begin
                        bcnt_q  <= '0;
                        ecnt_q  <= '0;
                        base_q  <= w_acc_b_nx;
                        r_q     <= c_one;
                        acc_b_q <= '0;
                        acc_r_q <= '0;
                    end else begin
                        acc_b_q <= w_acc_b_nx;
                    end
                end
                S_EXP: begin
                    bcnt_q <= bcnt_q + c_bit_one;
                    if (w_bit_last) begin
                        // Both products complete: commit R (if the exponent
                        // bit is set) and the squared base, then move on.
                        bcnt_q  <= '0;
                        ecnt_q  <= ecnt_q + c_bit_one;
                        acc_b_q <= '0;
                        acc_r_q <= '0;
                        base_q  <= w_acc_b_nx;
                        if (exp_q[ecnt_q]) begin
                            r_q <= w_acc_r_nx;
                        end
                        if (w_exp_last) begin
                            out_data_q   <= exp_q[ecnt_q] ? w_acc_r_nx : r_q;
                            out_cipher_q <= c_q;
                            out_index_q  <= idx_q;
                        end
                    end else begin
                        acc_b_q <= w_acc_b_nx;
                        acc_r_q <= w_acc_r_nx;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        idx_q <= idx_q + CNT_W'(1);
                        if (w_more) begin
                            addr_q <= addr_q + ADDR'(1);
                            fcnt_q <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr_o   = addr_q;
    assign out_data_o   = out_data_q;
    assign out_cipher_o = {{ARQ{1'b0}}, out_cipher_q};
    assign out_index_o  = out_index_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_modex_stream_decryptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_modex_stream_decryptor
// Description : Self-checking bench for modex_stream_decryptor. A behavioural
//               model (plain modular arithmetic over a memory image) feeds a
//               scoreboard of expected reads and results; one compare process
//               checks reads and outputs every cycle, and directed tests pin
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modex_stream_decryptor;

    localparam int ARQ   = 16;
    localparam int PIX   = 8;
    localparam int MEM_W = 16;
    localparam int ADDR  = 18;
    localparam int CNT_W = 16;
    localparam int NPIX  = ARQ / PIX;
    localparam int AMASK = (1 << ADDR) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [ADDR-1:0]    base_addr = '0;
    logic [CNT_W-1:0]   word_count = '0;
    logic [ARQ-1:0]     exponent = '0;
    logic [ARQ-1:0]     modulus = '0;
    logic               mem_re;
    logic [ADDR-1:0]    mem_addr;
    logic [MEM_W-1:0]   mem_rdata = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ARQ-1:0]     out_data;
    logic [2*ARQ-1:0]   out_cipher;
    logic [CNT_W-1:0]   out_index;
    logic               busy;
    logic               done;
    logic               err;

    modex_stream_decryptor #(
        .ARQ(ARQ), .PIX(PIX), .MEM_W(MEM_W), .ADDR(ADDR), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .word_count_i (word_count),
        .exponent_i   (exponent),
        .modulus_i    (modulus),
        .mem_re_o     (mem_re),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_cipher_o (out_cipher),
        .out_index_o  (out_index),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory image and one-cycle read response
    logic [MEM_W-1:0] mem [0:(1<<ADDR)-1];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint model_modexp(input longint c, input longint e, input longint n);
        longint r = 1;
        longint b = c % n;
        for (int i = 0; i < ARQ; i++) begin
            if (((e >> i) & 1) != 0) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r % n;
    endfunction

    function automatic longint model_cipher(input int a);
        longint c = 0;
        logic [MEM_W-1:0] w;
        for (int j = 0; j < NPIX; j++) begin
            w = mem[(a + j) & AMASK];
            c = (c << PIX) | longint'(w[PIX-1:0]);
        end
        return c;
    endfunction

    typedef struct {
        longint data;
        longint cipher;
        int     index;
    } item_t;

    item_t sb_q[$];
    int    rd_q[$];

    // Observation state shared with the directed tests
    bit     re_seen, val_seen;
    int     re_cyc, val_cyc;
    int     delivered;
    int     vcount [0:7];
    longint last_data, last_cipher;
    int     last_index;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re) begin
                if (!re_seen) begin re_seen = 1; re_cyc = cyc; end
                if (rd_q.size() == 0) chk("mem_re_unexpected", mem_re, 0);
                else chk("mem_addr", mem_addr, rd_q.pop_front());
            end
            if (out_valid) begin
                if (!val_seen) begin val_seen = 1; val_cyc = cyc; end
                if (sb_q.size() == 0) begin
                    chk("out_valid_unexpected", out_valid, 0);
                end else begin
                    chk("out_data",   out_data,   sb_q[0].data);
                    chk("out_cipher", out_cipher, sb_q[0].cipher);
                    chk("out_index",  out_index,  sb_q[0].index);
                    if (sb_q[0].index < 8) vcount[sb_q[0].index]++;
                    if (out_ready) begin
                        last_data   = out_data;
                        last_cipher = out_cipher;
                        last_index  = int'(out_index);
                        delivered++;
                        sb_q.delete(0);
                    end
                end
            end
        end
    end

    // Consumer: stalls a chosen word for stall_left cycles
    int stall_idx = -1;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        if (out_valid && int'(out_index) == stall_idx && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    int done_t;

    task automatic clear_obs();
        re_seen = 0; val_seen = 0; delivered = 0;
        for (int i = 0; i < 8; i++) vcount[i] = 0;
    endtask

    task automatic push_job(input int base, input int cnt, input longint e, input longint n);
        item_t it;
        for (int k = 0; k < cnt; k++) begin
            for (int j = 0; j < NPIX; j++) rd_q.push_back((base + k * NPIX + j) & AMASK);
            it.cipher = model_cipher(base + k * NPIX);
            it.data   = model_modexp(it.cipher, e, n);
            it.index  = k;
            sb_q.push_back(it);
        end
    endtask

    task automatic run_job(input int base, input int cnt, input longint e, input longint n,
                           input bit exp_err, input bit poke_start);
        bit got = 0;
        if (n >= 2) push_job(base, cnt, e, n);
        clear_obs();
        @(posedge clk); #1;
        base_addr = ADDR'(base); word_count = CNT_W'(cnt);
        exponent = ARQ'(e); modulus = ARQ'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the job inputs: they must already be latched.
        base_addr = ADDR'($urandom); exponent = ARQ'($urandom);
        modulus = 16'd5; word_count = 16'd7;
        done_t = -1;
        for (int t = 0; t < (cnt + 1) * 400 && !got; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1; done_t = t;
            end else if (poke_start && t == 40) begin
                start = 1'b1; modulus = 16'd7; base_addr = '0; word_count = 16'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("err_at_done", err, exp_err);
        chk("busy_at_done", busy, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("words_delivered", delivered, exp_err ? 0 : cnt);
        chk("pending_results", sb_q.size(), 0);
        chk("pending_reads", rd_q.size(), 0);
        sb_q.delete();
        rd_q.delete();
    endtask

    initial begin
        int dcount, vcnt;
        for (int i = 0; i < (1 << ADDR); i++) mem[i] = MEM_W'($urandom);
        mem['h100] = 16'h000A; mem['h101] = 16'h00E6;
        mem['h102] = 16'h7F12; mem['h103] = 16'h0034;
        mem['h104] = 16'hC356; mem['h105] = 16'h0078;
        mem['h200] = 16'h9911; mem['h201] = 16'h2222;
        mem['h300] = 16'h12FF; mem['h301] = 16'h34FF;
        mem['h3FFFF] = 16'hAA12; mem['h00000] = 16'h5534;
        clear_obs();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cipher", out_cipher, 0);
        chk("rst_out_index", out_index, 0);

        // Single word, textbook RSA pair
        run_job('h100, 1, 2753, 3233, 0, 0);
        chk("t1_data", last_data, 65);
        chk("t1_cipher", last_cipher, 'hAE6);
        chk("t1_index", last_index, 0);
        chk("t1_latency", val_cyc - re_cyc, 275);

        // Backpressure on word 1
        stall_idx = 1; stall_left = 10;
        run_job('h100, 3, 2753, 3233, 0, 0);
        chk("t2_valid_cycles_w0", vcount[0], 1);
        chk("t2_valid_cycles_w1", vcount[1], 11);
        chk("t2_valid_cycles_w2", vcount[2], 1);
        chk("t2_last_index", last_index, 2);
        stall_idx = -1;

        // Edge exponents
        run_job('h200, 1, 0, 3233, 0, 0);
        chk("t3_e0_data", last_data, 1);
        run_job('h100, 1, 1, 3233, 0, 0);
        chk("t4_e1_data", last_data, 2790);
        run_job('h300, 1, 1, 1349, 0, 0);
        chk("t5_ffff_cipher", last_cipher, 'hFFFF);
        chk("t5_ffff_data", last_data, 783);

        // Rejected modulus, then empty job (which must also clear err)
        run_job('h100, 1, 2753, 1, 1, 0);
        run_job('h100, 0, 2753, 3233, 0, 0);
        chk("t7_done_latency", done_t, 0);

        // Address wrap
        run_job('h3FFFF, 1, 17, 3233, 0, 0);
        chk("t8_wrap_cipher", last_cipher, 'h1234);

        // Start pulse while busy is ignored
        run_job('h100, 2, 2753, 3233, 0, 1);
        chk("t9_last_index", last_index, 1);
        chk("t9_last_cipher", last_cipher, 'h1234);

        // Reset in the middle of exponentiation
        push_job('h100, 1, 2753, 3233);
        clear_obs();
        @(posedge clk); #1;
        base_addr = 'h100; word_count = 1; exponent = 2753; modulus = 3233; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("t10_busy_mid", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        rd_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t10_busy", busy, 0);
        chk("t10_valid", out_valid, 0);
        chk("t10_done", done, 0);
        chk("t10_out_data", out_data, 0);
        dcount = 0; vcnt = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) dcount++;
            if (out_valid) vcnt++;
        end
        chk("t10_no_done", dcount, 0);
        chk("t10_no_valid", vcnt, 0);

        // Fresh job after reset
        run_job('h100, 1, 2753, 3233, 0, 0);
        chk("t11_data", last_data, 65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
